ysyx_22041207_hazard_ctrl: RTL and testbench

Central pipeline sequencer for the 5-stage core. It watches ID operands, EX control (load, redirect, trap) and the IFU/LSU busy handshakes. From these it drives the stall (hold) and flush (clear) controls of the PC, IF/ID, ID/EX and EX/MEM registers. The state machine resolves load-use, control redirects, trap drain and memory freezes with fixed priority.

---
 rtl/ysyx_22041207_pipe_pkg.sv | 21 ++
 rtl/ysyx_22041207_hazard_detect.sv | 25 ++
 rtl/ysyx_22041207_hazard_ctrl.sv | 172 +++++++++++++++++
 tb/tb_ysyx_22041207_hazard_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22041207_pipe_pkg.sv
// rtl/ysyx_22041207_pipe_pkg.sv - sequencer state encoding, stall cause codes and register constants
package ysyx_22041207_pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_DRAIN    = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    CAUSE_NONE     = 3'd0,
    CAUSE_LOAD_USE = 3'd1,
    CAUSE_REDIRECT = 3'd2,
    CAUSE_TRAP     = 3'd3,
    CAUSE_LSU      = 3'd4,
    CAUSE_IFU      = 3'd5
  } cause_e;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/ysyx_22041207_hazard_detect.sv
// rtl/ysyx_22041207_hazard_detect.sv - combinational load-use comparator between EX load and ID operands
module ysyx_22041207_hazard_detect
  import ysyx_22041207_pipe_pkg::*;
(
  input  logic [4:0] id_rs1addr,
  input  logic [4:0] id_rs2addr,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rwaddr,
  input  logic       ex_writeRD,
  input  logic       ex_memoryReadWen,
  output logic       lu_hit
);

  logic ex_load_wr;
  logic rs1_match;
  logic rs2_match;

  // x0 is hardwired to zero, so a load "writing" it never creates a dependency
  assign ex_load_wr = ex_memoryReadWen & ex_writeRD & (ex_rwaddr != REG_X0);
  assign rs1_match  = id_use_rs1 & (id_rs1addr == ex_rwaddr);
  assign rs2_match  = id_use_rs2 & (id_rs2addr == ex_rwaddr);
  assign lu_hit     = ex_load_wr & (rs1_match | rs2_match);

endmodule

// File: rtl/ysyx_22041207_hazard_ctrl.sv
// rtl/ysyx_22041207_hazard_ctrl.sv - pipeline stall/flush sequencer for the 5-stage core
// Optional perf counters enabled by defining HAZARD_CTRL_PERF_EN.
module ysyx_22041207_hazard_ctrl
  import ysyx_22041207_pipe_pkg::*;
#(
  parameter int LOAD_USE_STALL = 1,
  parameter int TRAP_DRAIN     = 2,
  parameter int PERF_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        id_rs1addr,
  input  logic [4:0]        id_rs2addr,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [4:0]        ex_rwaddr,
  input  logic              ex_writeRD,
  input  logic              ex_memoryReadWen,
  input  logic              ex_redirect,
  input  logic              ex_trap,
  input  logic              ifu_busy,
  input  logic              lsu_busy,
  output logic              pc_stall,
  output logic              if_id_bubble,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              id_ex_flush,
  output logic              ex_mem_bubble,
  output logic              ex_mem_flush,
  output logic [2:0]        stall_cause,
  output logic [PERF_W-1:0] perf_stall_cycles,
  output logic [PERF_W-1:0] perf_flush_count
);

  localparam logic [2:0] LU_CNT   = 3'(LOAD_USE_STALL - 1);
  localparam logic [2:0] TRAP_CNT = 3'(TRAP_DRAIN - 1);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  cause_e     cause_d;
  logic       lu_hit;

  ysyx_22041207_hazard_detect u_detect (
    .id_rs1addr       (id_rs1addr),
    .id_rs2addr       (id_rs2addr),
    .id_use_rs1       (id_use_rs1),
    .id_use_rs2       (id_use_rs2),
    .ex_rwaddr        (ex_rwaddr),
    .ex_writeRD       (ex_writeRD),
    .ex_memoryReadWen (ex_memoryReadWen),
    .lu_hit           (lu_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cause_d       = CAUSE_NONE;
    pc_stall      = 1'b0;
    if_id_bubble  = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    ex_mem_flush  = 1'b0;
    // Pipeline registers have no reset of their own; keep them cleared while reset is held
    if (!rst_n) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      state_d      = ST_RUN;
      cnt_d        = 3'd0;
    end else if (lsu_busy) begin
      pc_stall      = 1'b1;
      if_id_bubble  = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
      cause_d       = CAUSE_LSU;
    end else if (ex_trap) begin
      pc_stall    = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      cause_d     = CAUSE_TRAP;
      if (TRAP_DRAIN > 1) begin
        state_d = ST_DRAIN;
        cnt_d   = TRAP_CNT;
      end else begin
        state_d = ST_RUN;
        cnt_d   = 3'd0;
      end
    end else if (ex_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      cause_d     = CAUSE_REDIRECT;
      state_d     = ST_RUN;
      cnt_d       = 3'd0;
    end else if (state_q == ST_DRAIN) begin
      pc_stall    = 1'b1;
      if_id_flush = 1'b1;
      cause_d     = CAUSE_TRAP;
      cnt_d       = cnt_q - 3'd1;
      if (cnt_q <= 3'd1) begin
        state_d = ST_RUN;
        cnt_d   = 3'd0;
      end
    end else if ((state_q == ST_LU_STALL) || lu_hit) begin
      pc_stall     = 1'b1;
      if_id_bubble = 1'b1;
      id_ex_flush  = 1'b1;
      cause_d      = CAUSE_LOAD_USE;
      // cnt counts the stall cycles still owed after the current one
      if (state_q == ST_LU_STALL) begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) begin
          state_d = ST_RUN;
          cnt_d   = 3'd0;
        end
      end else if (LOAD_USE_STALL > 1) begin
        state_d = ST_LU_STALL;
        cnt_d   = LU_CNT;
      end
    end else if (ifu_busy) begin
      pc_stall    = 1'b1;
      if_id_flush = 1'b1;
      cause_d     = CAUSE_IFU;
    end
  end

  assign stall_cause = cause_d;

`ifdef HAZARD_CTRL_PERF_EN
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_stall) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if ((ex_trap | ex_redirect) & ~lsu_busy) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cycles = stall_cnt_q;
  assign perf_flush_count  = flush_cnt_q;
`else
  assign perf_stall_cycles = '0;
  assign perf_flush_count  = '0;
`endif

endmodule

// File: tb/tb_ysyx_22041207_hazard_ctrl.sv
// tb/tb_ysyx_22041207_hazard_ctrl.sv - directed self-checking bench for the hazard sequencer
module tb_ysyx_22041207_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs1addr, id_rs2addr, ex_rwaddr;
  logic        id_use_rs1, id_use_rs2, ex_writeRD, ex_memoryReadWen;
  logic        ex_redirect, ex_trap, ifu_busy, lsu_busy;
  logic        pc_stall, if_id_bubble, if_id_flush, id_ex_bubble, id_ex_flush;
  logic        ex_mem_bubble, ex_mem_flush;
  logic [2:0]  stall_cause;
  logic [31:0] perf_stall_cycles, perf_flush_count;

  int n_pass = 0;
  int n_total = 0;

  // {pc_stall, if_id_bubble, if_id_flush, id_ex_bubble, id_ex_flush, ex_mem_bubble, ex_mem_flush}
  localparam logic [6:0] O_IDLE   = 7'b0000000;
  localparam logic [6:0] O_RESET  = 7'b0010101;
  localparam logic [6:0] O_LU     = 7'b1100100;
  localparam logic [6:0] O_REDIR  = 7'b0010100;
  localparam logic [6:0] O_TRAP   = 7'b1010100;
  localparam logic [6:0] O_DRAIN  = 7'b1010000;
  localparam logic [6:0] O_FREEZE = 7'b1101010;

  always #5 clk = ~clk;

  ysyx_22041207_hazard_ctrl #(
    .LOAD_USE_STALL (2),
    .TRAP_DRAIN     (2),
    .PERF_W         (32)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .id_rs1addr        (id_rs1addr),
    .id_rs2addr        (id_rs2addr),
    .id_use_rs1        (id_use_rs1),
    .id_use_rs2        (id_use_rs2),
    .ex_rwaddr         (ex_rwaddr),
    .ex_writeRD        (ex_writeRD),
    .ex_memoryReadWen  (ex_memoryReadWen),
    .ex_redirect       (ex_redirect),
    .ex_trap           (ex_trap),
    .ifu_busy          (ifu_busy),
    .lsu_busy          (lsu_busy),
    .pc_stall          (pc_stall),
    .if_id_bubble      (if_id_bubble),
    .if_id_flush       (if_id_flush),
    .id_ex_bubble      (id_ex_bubble),
    .id_ex_flush       (id_ex_flush),
    .ex_mem_bubble     (ex_mem_bubble),
    .ex_mem_flush      (ex_mem_flush),
    .stall_cause       (stall_cause),
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_count  (perf_flush_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_out(input string tag, input logic [6:0] exp_o, input logic [2:0] exp_c);
    check({tag, ".ctl"}, 32'({pc_stall, if_id_bubble, if_id_flush, id_ex_bubble,
                               id_ex_flush, ex_mem_bubble, ex_mem_flush}), 32'(exp_o));
    check({tag, ".cause"}, 32'(stall_cause), 32'(exp_c));
  endtask

  task automatic clear_in();
    id_rs1addr = 5'd0; id_rs2addr = 5'd0; ex_rwaddr = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_writeRD = 1'b0; ex_memoryReadWen = 1'b0;
    ex_redirect = 1'b0; ex_trap = 1'b0; ifu_busy = 1'b0; lsu_busy = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] rd);
    ex_memoryReadWen = 1'b1; ex_writeRD = 1'b1; ex_rwaddr = rd;
  endtask

  // inputs change 1 time unit after posedge; outputs are sampled on the negedge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_in();
    @(negedge clk);
    check_out("reset", O_RESET, 3'd0);
    check("reset.perf_stall", perf_stall_cycles, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk) check_out("idle", O_IDLE, 3'd0);

    next_cycle();
    set_load(5'd5); id_rs1addr = 5'd5; id_use_rs1 = 1'b1;
    @(negedge clk) check_out("lu.c1", O_LU, 3'd1);
    next_cycle();
    clear_in();
    @(negedge clk) check_out("lu.c2", O_LU, 3'd1);
    next_cycle();
    @(negedge clk) check_out("lu.done", O_IDLE, 3'd0);

    next_cycle();
    set_load(5'd0); id_rs1addr = 5'd0; id_use_rs1 = 1'b1;
    @(negedge clk) check_out("lu.x0", O_IDLE, 3'd0);
    next_cycle();
    set_load(5'd9); id_rs1addr = 5'd9; id_use_rs1 = 1'b0;
    @(negedge clk) check_out("lu.nouse", O_IDLE, 3'd0);
    next_cycle();
    clear_in(); ex_writeRD = 1'b1; ex_rwaddr = 5'd9; id_rs1addr = 5'd9; id_use_rs1 = 1'b1;
    @(negedge clk) check_out("lu.noload", O_IDLE, 3'd0);

    next_cycle();
    clear_in(); set_load(5'd7); id_rs2addr = 5'd7; id_use_rs2 = 1'b1; id_rs1addr = 5'd3; id_use_rs1 = 1'b1;
    @(negedge clk) check_out("lu.rs2", O_LU, 3'd1);
    next_cycle();
    clear_in(); ex_redirect = 1'b1;
    @(negedge clk) check_out("redir.in_lu", O_REDIR, 3'd2);
    next_cycle();
    clear_in();
    @(negedge clk) check_out("redir.run", O_IDLE, 3'd0);

    next_cycle();
    ex_trap = 1'b1;
    @(negedge clk) check_out("trap.c1", O_TRAP, 3'd3);
    next_cycle();
    clear_in();
    @(negedge clk) check_out("trap.drain", O_DRAIN, 3'd3);
    next_cycle();
    @(negedge clk) check_out("trap.done", O_IDLE, 3'd0);

    for (int i = 0; i < 3; i++) begin
      next_cycle();
      ex_trap = 1'b1; lsu_busy = 1'b1;
      @(negedge clk) check_out($sformatf("freeze.%0d", i), O_FREEZE, 3'd4);
    end
    next_cycle();
    lsu_busy = 1'b0;
    @(negedge clk) check_out("freeze.trap", O_TRAP, 3'd3);
    next_cycle();
    clear_in();
    @(negedge clk) check_out("freeze.drain", O_DRAIN, 3'd3);
    next_cycle();
    ifu_busy = 1'b1;
    @(negedge clk) check_out("ifu", O_DRAIN, 3'd5);

    next_cycle();
    clear_in(); ex_trap = 1'b1;
    @(negedge clk) check_out("rst.trap", O_TRAP, 3'd3);
    next_cycle();
    clear_in(); rst_n = 1'b0;
    @(negedge clk) check_out("rst.mid_drain", O_RESET, 3'd0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk) begin
      check_out("rst.run", O_IDLE, 3'd0);
      check("rst.perf_stall", perf_stall_cycles, 32'd0);
      check("rst.perf_flush", perf_flush_count, 32'd0);
    end

    for (int i = 0; i < 3; i++) begin
      next_cycle();
      lsu_busy = 1'b1; ex_redirect = 1'b1;
      @(negedge clk) check_out($sformatf("perf.freeze%0d", i), O_FREEZE, 3'd4);
    end
    next_cycle();
    lsu_busy = 1'b0;
    @(negedge clk) check_out("perf.redir", O_REDIR, 3'd2);
    next_cycle();
    clear_in();
    @(negedge clk) begin
`ifdef HAZARD_CTRL_PERF_EN
      check("perf.stall_cycles", perf_stall_cycles, 32'd3);
      check("perf.flush_count", perf_flush_count, 32'd1);
`else
      check("perf.stall_cycles", perf_stall_cycles, 32'd0);
      check("perf.flush_count", perf_flush_count, 32'd0);
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
